// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding select encodings and the per-stage
// shadow control record used by the hazard/forwarding logic.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_ctrl_t;

  // True when a stage will write a non-x0 register that matches rs.
  function automatic logic writes_reg(stage_ctrl_t s, logic [REG_ADDR_W-1:0] rs);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding source select for one EX operand; the newer EX/MEM result
// always beats the older MEM/WB result.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  stage_ctrl_t           exmem,
  input  stage_ctrl_t           memwb,
  output logic [1:0]            sel
);

  logic unused_mem_read;
  assign unused_mem_read = &{1'b0, exmem.mem_read, memwb.mem_read};

  always_comb begin
    sel = FWD_ID;
    if (writes_reg(exmem, rs)) begin
      sel = FWD_MEM;
    end else if (writes_reg(memwb, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: shadows ID/EX, EX/MEM and MEM/WB
// control, drives operand forwarding, load-use stalls, branch flushes and a
// saturating stall-cycle counter.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_count
);

  import pipeline_pkg::*;

  stage_ctrl_t           idex, exmem, memwb;
  logic [REG_ADDR_W-1:0] idex_rs1, idex_rs2;
  logic                  load_use;
  logic                  stall_inc;

  fwd_select u_fwd_a (.rs(idex_rs1), .exmem(exmem), .memwb(memwb), .sel(fwd_a_sel));
  fwd_select u_fwd_b (.rs(idex_rs2), .exmem(exmem), .memwb(memwb), .sel(fwd_b_sel));

  // rs2 is compared even for instructions that do not use it; a spurious
  // match only costs a cycle.
  assign load_use = idex.valid && idex.mem_read && (idex.rd != '0) && id_valid &&
                    ((idex.rd == id_rs1) || (idex.rd == id_rs2));

  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    stall_inc     = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
      end else if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_bubble   = 1'b1;
        stall_inc     = 1'b1;
      end
    end
  end

  // Shadow pipeline moves in lock-step with the datapath; mem_wait freezes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex        <= '0;
      exmem       <= '0;
      memwb       <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      stall_count <= '0;
    end else if (!mem_wait) begin
      memwb <= exmem;
      exmem <= idex;
      if (idex_bubble) begin
        idex     <= '0;
        idex_rs1 <= '0;
        idex_rs2 <= '0;
      end else begin
        idex     <= '{valid:     id_valid,
                      rd:        id_rd,
                      reg_write: id_reg_write & id_valid,
                      mem_read:  id_mem_read & id_valid};
        idex_rs1 <= id_rs1;
        idex_rs2 <= id_rs2;
      end
      if (stall_inc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed pipeline scenarios plus
// random traffic, checked against an instruction-level pipeline model.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic        ex_branch_taken = 1'b0, mem_wait = 1'b0;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic [31:0] stall_count;

  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write_en(pc_write_en),
    .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rs1, rs2, rd;
    bit wr, ld;
  } instr_t;

  typedef struct {
    logic [1:0]  fa, fb;
    logic        pc, ifid, flush, bubble;
    logic [31:0] cnt;
  } exp_t;

  // pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
  instr_t      pipe[3], pipe_n[3];
  instr_t      empty_instr;
  logic [31:0] cnt, cnt_n;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_fail = 0;

  // Select = how many stages ahead the newest matching producer sits.
  function automatic logic [1:0] fwd(int rs);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].valid && pipe[s].wr && pipe[s].rd != 0 && pipe[s].rd == rs)
        return 2'(s);
    return 2'b00;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input int rs1, input int rs2,
                               input int rd, input bit wr, input bit ld,
                               input bit br, input bit mw);
    exp_t e;
    bit   lu;
    rst = r; id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_reg_write = wr; id_mem_read = ld; ex_branch_taken = br; mem_wait = mw;
    if (r) begin
      for (int s = 0; s < 3; s++) pipe[s] = empty_instr;
      cnt = 0;
    end
    e.fa = fwd(pipe[0].rs1);
    e.fb = fwd(pipe[0].rs2);
    e.cnt = cnt;
    e.pc = 1; e.ifid = 1; e.flush = 0; e.bubble = 0;
    lu = pipe[0].valid && pipe[0].ld && pipe[0].rd != 0 && v &&
         (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    if (!r) begin
      if (mw) begin
        e.pc = 0; e.ifid = 0;
      end else if (br) begin
        e.flush = 1; e.bubble = 1;
      end else if (lu) begin
        e.pc = 0; e.ifid = 0; e.bubble = 1;
      end
    end
    q.push_back(e);
    pipe_n = pipe;
    cnt_n = cnt;
    if (!r && !mw) begin
      pipe_n[2] = pipe[1];
      pipe_n[1] = pipe[0];
      if (e.bubble) pipe_n[0] = empty_instr;
      else pipe_n[0] = '{valid: v, rs1: rs1, rs2: rs2, rd: rd, wr: wr && v, ld: ld && v};
      if (!br && lu && cnt != 32'hFFFF_FFFF) cnt_n = cnt + 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input int rs1, input int rs2,
                      input int rd, input bit wr, input bit ld,
                      input bit br, input bit mw);
    @(posedge clk);
    #1;
    pipe = pipe_n;
    cnt = cnt_n;
    applyStimulus(r, v, rs1, rs2, rd, wr, ld, br, mw);
  endtask

  task automatic nop(input bit mw);
    step(0, 0, 0, 0, 0, 0, 0, 0, mw);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
        checkOutput("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
        checkOutput("pc_write_en", 32'(pc_write_en), 32'(e.pc));
        checkOutput("ifid_write_en", 32'(ifid_write_en), 32'(e.ifid));
        checkOutput("ifid_flush", 32'(ifid_flush), 32'(e.flush));
        checkOutput("idex_bubble", 32'(idex_bubble), 32'(e.bubble));
        checkOutput("stall_count", stall_count, e.cnt);
      end
    end
  end

  initial begin
    empty_instr = '{valid: 0, rs1: 0, rs2: 0, rd: 0, wr: 0, ld: 0};
    for (int s = 0; s < 3; s++) begin
      pipe[s] = empty_instr;
      pipe_n[s] = empty_instr;
    end
    cnt = 0;
    cnt_n = 0;
    $display("[TB] start");

    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0);

    // add x3,x1,x2 ; sub x5,x3,x4
    step(0, 1, 1, 2, 3, 1, 0, 0, 0);
    step(0, 1, 3, 4, 5, 1, 0, 0, 0);
    repeat (4) nop(0);

    // two writers of x3 then a reader
    step(0, 1, 1, 2, 3, 1, 0, 0, 0);
    step(0, 1, 4, 5, 3, 1, 0, 0, 0);
    step(0, 1, 3, 3, 8, 1, 0, 0, 0);
    repeat (4) nop(0);

    // lw x6,0(x1) ; add x7,x6,x2 (held in IF/ID during the stall)
    step(0, 1, 1, 0, 6, 1, 1, 0, 0);
    step(0, 1, 6, 2, 7, 1, 0, 0, 0);
    step(0, 1, 6, 2, 7, 1, 0, 0, 0);
    repeat (4) nop(0);

    // writer and load of x0, then reader of x0
    step(0, 1, 1, 2, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 9, 1, 0, 0, 0);
    repeat (4) nop(0);

    // load-use coinciding with a taken branch
    step(0, 1, 1, 0, 6, 1, 1, 0, 0);
    step(0, 1, 6, 2, 7, 1, 0, 1, 0);
    repeat (4) nop(0);

    // forwarding case frozen by mem_wait, then reset mid-wait
    step(0, 1, 1, 2, 3, 1, 0, 0, 0);
    step(0, 1, 3, 4, 5, 1, 0, 0, 0);
    repeat (3) nop(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(0);
    nop(0);

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(99) == 0, $urandom_range(3) != 0,
           $urandom_range(7), $urandom_range(7), $urandom_range(7),
           $urandom_range(1), $urandom_range(2) == 0,
           $urandom_range(9) == 0, $urandom_range(9) == 0);
    end

    repeat (2) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
